// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared types and constants for the frame-buffer writer.
//                Holds the writer FSM state enum, the Wishbone cycle-type
//                codes used for the burst tag, and the 24-bit RGB pixel
//                type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

   // Writer FSM: SYNC waits for a start-of-frame pixel, RUN streams a frame.
   typedef enum logic [0:0] {
      SYNC = 1'b0,
      RUN  = 1'b1
   } fb_state_t;

   // Wishbone cycle type identifiers.
   localparam logic [2:0] CTI_INCR = 3'b010;   // incrementing burst
   localparam logic [2:0] CTI_EOB  = 3'b111;   // end of burst

   localparam int PIX_W = 24;
   typedef logic [PIX_W-1:0] pixel_t;           // {R,G,B}

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_hold_reg
//  Description : Single-entry valid/ready holding register for one pixel
//                write (pixel, byte address, last-of-frame tag).
//                Ports:
//                  clk, rst            clock, synchronous active-high reset
//                  load                capture load_* this cycle
//                  load_pix/adr/last   entry to capture
//                  ack                 downstream retires the held entry
//                  ready               entry free or being retired now
//                  hold_v              entry valid
//                  pix/adr/last        held entry, stable until retired
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_hold_reg
   import fb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [23:0] load_pix,
   input  logic [31:0] load_adr,
   input  logic        load_last,
   input  logic        ack,
   output logic        ready,
   output logic        hold_v,
   output logic [23:0] pix,
   output logic [31:0] adr,
   output logic        last
);

   logic        r_hold_v;
   pixel_t      r_pix;
   logic [31:0] r_adr;
   logic        r_last;

   // Load has priority over retire so that a new entry can replace the one
   // being acked in the same cycle. An ack while empty leaves hold_v at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_v <= 1'b0;
      end else if (load) begin
         r_hold_v <= 1'b1;
      end else if (ack) begin
         r_hold_v <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed while hold_v is set.
   always_ff @(posedge clk) begin
      if (load) begin
         r_pix  <= load_pix;
         r_adr  <= load_adr;
         r_last <= load_last;
      end
   end

   assign ready  = !r_hold_v || ack;
   assign hold_v = r_hold_v;
   assign pix    = r_pix;
   assign adr    = r_adr;
   assign last   = r_last;

endmodule : fb_hold_reg
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : fb_writer
//  Description : Streams RGB pixels into an SDRAM frame buffer over a
//                Wishbone master, one 32-bit word per pixel at
//                BASE_ADDR + 4*index. Locks onto pix_sof, resynchronises on
//                an early pix_sof and flags it.
//                Ports:
//                  wshb_ifm_clk/rst    clock, synchronous active-high reset
//                  pix_valid/ready     upstream pixel handshake
//                  pix_data, pix_sof   {R,G,B} pixel, frame-start marker
//                  wshb_ifm_*          Wishbone master (cyc..bte out, ack in)
//                  frame_done          pulse on ack of the last frame pixel
//                  resync_err          pulse on pix_sof at nonzero index
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_writer
   import fb_pkg::*;
#(
   parameter int          HDISP     = 800,
   parameter int          VDISP     = 480,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        wshb_ifm_clk,
   input  logic        wshb_ifm_rst,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [23:0] pix_data,
   input  logic        pix_sof,
   output logic        wshb_ifm_cyc,
   output logic        wshb_ifm_stb,
   output logic        wshb_ifm_we,
   output logic [31:0] wshb_ifm_adr,
   output logic [31:0] wshb_ifm_dat_ms,
   output logic [3:0]  wshb_ifm_sel,
   output logic [2:0]  wshb_ifm_cti,
   output logic [1:0]  wshb_ifm_bte,
   input  logic        wshb_ifm_ack,
   output logic        frame_done,
   output logic        resync_err
);

   localparam int NPIX  = HDISP * VDISP;
   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   fb_state_t        r_state;
   fb_state_t        w_state_nxt;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] w_load_idx;
   logic             w_load;
   logic             w_load_last;
   logic             w_resync;
   logic             w_xfer;
   logic [31:0]      w_load_adr;

   logic             w_ready;
   logic             w_hold_v;
   logic [23:0]      w_hold_pix;
   logic [31:0]      w_hold_adr;
   logic             w_hold_last;

   assign w_xfer = pix_valid && w_ready;

   always_ff @(posedge wshb_ifm_clk) begin
      if (wshb_ifm_rst) begin
         r_state <= SYNC;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Every accepted pixel is written at load_idx: 0 on pix_sof, the running
   // pointer otherwise. The pointer then advances from load_idx, so a resync
   // leaves it at 1 and the last pixel of a frame wraps it to 0 and re-arms
   // SYNC. Non-sof pixels seen in SYNC are accepted and discarded.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      w_load_idx  = '0;
      w_resync    = 1'b0;
      w_load_last = 1'b0;

      case (r_state)
         SYNC: begin
            if (w_xfer && pix_sof) begin
               w_load = 1'b1;
            end
         end
         RUN: begin
            if (w_xfer) begin
               w_load = 1'b1;
               if (pix_sof) begin
                  w_resync = (r_idx != '0);
               end else begin
                  w_load_idx = r_idx;
               end
            end
         end
         default: begin
            w_state_nxt = SYNC;
         end
      endcase

      w_load_last = (w_load_idx == LAST_IDX);
      if (w_load) begin
         if (w_load_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = SYNC;
         end else begin
            w_idx_nxt   = w_load_idx + IDX_W'(1);
            w_state_nxt = RUN;
         end
      end
   end

   assign w_load_adr = BASE_ADDR + (32'(w_load_idx) << 2);

   fb_hold_reg u_hold (
      .clk       (wshb_ifm_clk),
      .rst       (wshb_ifm_rst),
      .load      (w_load),
      .load_pix  (pix_data),
      .load_adr  (w_load_adr),
      .load_last (w_load_last),
      .ack       (wshb_ifm_ack),
      .ready     (w_ready),
      .hold_v    (w_hold_v),
      .pix       (w_hold_pix),
      .adr       (w_hold_adr),
      .last      (w_hold_last)
   );

   assign pix_ready       = w_ready;
   assign wshb_ifm_cyc    = w_hold_v;
   assign wshb_ifm_stb    = w_hold_v;
   assign wshb_ifm_we     = 1'b1;
   assign wshb_ifm_adr    = w_hold_adr;
   assign wshb_ifm_dat_ms = {8'h00, w_hold_pix};
   assign wshb_ifm_sel    = 4'b1111;
   assign wshb_ifm_cti    = w_hold_last ? CTI_EOB : CTI_INCR;
   assign wshb_ifm_bte    = 2'b00;

   // Pulses are masked during reset, when the held state is being cleared.
   assign frame_done = !wshb_ifm_rst && w_hold_v && wshb_ifm_ack && w_hold_last;
   assign resync_err = !wshb_ifm_rst && w_resync;

endmodule : fb_writer
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_writer
//  Description : Self-checking bench for fb_writer (HDISP=4, VDISP=2,
//                BASE_ADDR=0x100). A reference model turns every accepted
//                pixel into the write it should produce (address, data,
//                last tag) and a FIFO of those is matched against bus
//                writes. Directed scenarios with random data/handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_writer;

   localparam int          HDISP = 4;
   localparam int          VDISP = 2;
   localparam int          NPIX  = HDISP * VDISP;
   localparam logic [31:0] BASE  = 32'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid;
   logic        pix_ready;
   logic [23:0] pix_data;
   logic        pix_sof;
   logic        cyc, stb, we, ack;
   logic [31:0] adr, dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        frame_done, resync_err;

   fb_writer #(.HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE)) dut (
      .wshb_ifm_clk    (clk),
      .wshb_ifm_rst    (rst),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_data        (pix_data),
      .pix_sof         (pix_sof),
      .wshb_ifm_cyc    (cyc),
      .wshb_ifm_stb    (stb),
      .wshb_ifm_we     (we),
      .wshb_ifm_adr    (adr),
      .wshb_ifm_dat_ms (dat_ms),
      .wshb_ifm_sel    (sel),
      .wshb_ifm_cti    (cti),
      .wshb_ifm_bte    (bte),
      .wshb_ifm_ack    (ack),
      .frame_done      (frame_done),
      .resync_err      (resync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [23:0] dat;
      logic        last;
   } wr_t;

   typedef struct {
      logic        sof;
      logic [23:0] dat;
   } px_t;

   wr_t exp_q[$];
   px_t src[$];

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_writes = 0;
   int          n_fd     = 0;
   int          n_rs     = 0;
   bit          synced   = 0;
   int          pos      = 0;
   bit          hold_pend = 0;
   logic [31:0] hold_adr_s, hold_dat_s;
   bit          ack_rand   = 0;
   bit          valid_rand = 0;
   int          stall_left = 0;
   logic [31:0] stall_at   = 32'hFFFF_FFFF;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Frame rules: nothing is written until a pix_sof; pix_sof always lands at
   // pixel 0 and is an error when the frame was partway through; after
   // NPIX pixels the writer waits for the next pix_sof.
   task automatic model_accept(input logic sof, input logic [23:0] d, output bit rs);
      wr_t e;
      rs = 0;
      if (sof) begin
         rs     = synced && (pos != 0);
         e.adr  = BASE;
         e.dat  = d;
         e.last = (NPIX == 1);
         exp_q.push_back(e);
         pos    = 1;
         synced = 1;
      end else if (synced) begin
         e.adr  = BASE + 32'(4 * pos);
         e.dat  = d;
         e.last = (pos == NPIX - 1);
         exp_q.push_back(e);
         pos++;
      end
      if (synced && pos == NPIX) begin
         synced = 0;
         pos    = 0;
      end
   endtask

   // One clock cycle, entered and left at posedge+1.
   task automatic step();
      bit  v, a, rs;
      px_t cur;
      wr_t front;
      cur.sof = 1'b0;
      cur.dat = '0;
      if (src.size() > 0) cur = src[0];
      v = (src.size() > 0) && (!valid_rand || ($urandom_range(0, 1) == 1));
      a = ack_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (stb && adr == stall_at && stall_left > 0) begin
         a = 1'b0;
         stall_left--;
      end
      pix_valid = v;
      pix_sof   = v ? cur.sof : 1'($urandom_range(0, 1));
      pix_data  = v ? cur.dat : 24'($urandom);
      ack       = a;

      @(negedge clk);
      if (hold_pend) begin
         chk("hold_stb", stb, 1);
         chk("hold_adr", adr, hold_adr_s);
         chk("hold_dat", dat_ms, hold_dat_s);
      end
      chk("cyc_eq_stb", cyc, stb);
      if (stb && ack) begin
         n_writes++;
         chk("write_pending", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            front = exp_q.pop_front();
            chk("wr_adr", adr, front.adr);
            chk("wr_dat", dat_ms, {8'h00, front.dat});
            chk("wr_cti", cti, front.last ? 3'b111 : 3'b010);
            chk("frame_done", frame_done, front.last);
            chk("wr_const", {we, sel, bte}, 7'b1_1111_00);
         end
      end else begin
         chk("frame_done_idle", frame_done, 0);
      end
      if (stb && !ack) begin
         chk("ready_stall", pix_ready, 0);
         hold_pend  = 1;
         hold_adr_s = adr;
         hold_dat_s = dat_ms;
      end else begin
         hold_pend = 0;
      end
      if (frame_done) n_fd++;
      if (resync_err) n_rs++;
      rs = 0;
      if (v && pix_ready) begin
         model_accept(cur.sof, cur.dat, rs);
         void'(src.pop_front());
      end
      chk("resync_err", resync_err, rs);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string name, input int budget);
      int c = 0;
      while ((src.size() > 0 || exp_q.size() > 0 || stb) && c < budget) begin
         step();
         c++;
      end
      chk({name, "_timeout"}, 64'(c >= budget), 0);
      if (c >= budget) begin
         src.delete();
         exp_q.delete();
      end
   endtask

   task automatic do_reset(input int n);
      pix_valid = 0;
      pix_sof   = 0;
      ack       = 0;
      rst       = 1;
      repeat (n) @(posedge clk);
      #1;
      rst = 0;
      exp_q.delete();
      src.delete();
      synced     = 0;
      pos        = 0;
      hold_pend  = 0;
      stall_left = 0;
   endtask

   task automatic add_frame(input int sof_at, input int count);
      px_t p;
      for (int i = 0; i < count; i++) begin
         p.sof = (i == sof_at);
         p.dat = 24'($urandom);
         src.push_back(p);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, f0, r0, c;
      pix_data = '0;
      do_reset(3);

      // Reset state
      chk("rst_ready", pix_ready, 1);
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_resync", resync_err, 0);

      // Unsynchronised pixels dropped, then one full frame with ack held high
      w0 = n_writes; f0 = n_fd;
      add_frame(-1, 3);
      add_frame(0, NPIX);
      run("frame1", 100);
      chk("frame1_writes", n_writes - w0, NPIX);
      chk("frame1_done", n_fd - f0, 1);

      // Five-cycle ack stall on the third pixel
      w0 = n_writes; f0 = n_fd;
      stall_at = BASE + 32'h8; stall_left = 5;
      add_frame(0, NPIX);
      run("stall", 100);
      chk("stall_used", stall_left, 0);
      chk("stall_writes", n_writes - w0, NPIX);
      chk("stall_done", n_fd - f0, 1);
      stall_at = 32'hFFFF_FFFF;

      // Early pix_sof on the fourth pixel
      w0 = n_writes; f0 = n_fd; r0 = n_rs;
      add_frame(0, 3);
      add_frame(0, NPIX);
      run("resync", 100);
      chk("resync_writes", n_writes - w0, 3 + NPIX);
      chk("resync_pulses", n_rs - r0, 1);
      chk("resync_done", n_fd - f0, 1);

      // Reset while a write at 0x10C is open
      add_frame(0, NPIX);
      stall_at = BASE + 32'hC; stall_left = 1000;
      c = 0;
      while (!(stb && adr == BASE + 32'hC) && c < 20) begin
         step();
         c++;
      end
      chk("pre_rst_adr", adr, BASE + 32'hC);
      chk("pre_rst_stb", stb, 1);
      do_reset(1);
      stall_at = 32'hFFFF_FFFF;
      chk("post_rst_cyc", cyc, 0);
      chk("post_rst_ready", pix_ready, 1);
      w0 = n_writes; f0 = n_fd;
      add_frame(0, NPIX);
      run("after_rst", 100);
      chk("after_rst_writes", n_writes - w0, NPIX);
      chk("after_rst_done", n_fd - f0, 1);

      // Two back-to-back frames, random valid and ack
      w0 = n_writes; f0 = n_fd; r0 = n_rs;
      ack_rand = 1; valid_rand = 1;
      add_frame(0, NPIX);
      add_frame(0, NPIX);
      run("random", 400);
      chk("random_writes", n_writes - w0, 2 * NPIX);
      chk("random_done", n_fd - f0, 2);
      chk("random_resync", n_rs - r0, 0);
      ack_rand = 0; valid_rand = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fb_writer
`default_nettype wire
